// File: rtl/exc_commit_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : exc_commit_sequencer
// Purpose  : Sequences one trap event (interrupt, synchronous exception or
//            ERET) taken at commit through pipeline flush, memory drain,
//            CP0 state update and PC redirect, stalling commit throughout.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: EXC_SEQ_PERF_CNT_EN
//   defined   -> perf_trap_cnt / perf_stall_cnt are live 32-bit counters
//   undefined -> both ports tied to 0, no counter flops
// ----------------------------------------------------------------------------
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   commit_valid/pc/in_delay_slot  committing instruction info
//   exc_valid/code/badvaddr     synchronous exception from commit
//   eret_valid                  committing instruction is ERET
//   int_pending                 Cause.IP & Status.IM
//   status_ie/exl/erl, cp0_epc  CP0 state inputs
//   mem_busy                    outstanding data-bus transaction
//   redirect_ready              fetch accepts the redirect
//   flush, stall, busy          pipeline control / status
//   cp0_exc_*, cp0_badvaddr_*   CP0 exception update
//   cp0_eret_we                 CP0 ERET update (clear EXL)
//   redirect_valid/pc           fetch redirect request
//   perf_trap_cnt/stall_cnt     optional performance counters
// ============================================================================
module exc_commit_sequencer #(
  parameter logic [31:0] EXC_ENTRY     = 32'hBFC0_0380,
  parameter int          DRAIN_TIMEOUT = 16,
  parameter int          INT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 commit_valid,
  input  logic [31:0]          commit_pc,
  input  logic                 commit_in_delay_slot,
  input  logic                 exc_valid,
  input  logic [4:0]           exc_code,
  input  logic [31:0]          exc_badvaddr,
  input  logic                 eret_valid,
  input  logic [INT_WIDTH-1:0] int_pending,
  input  logic                 status_ie,
  input  logic                 status_exl,
  input  logic                 status_erl,
  input  logic [31:0]          cp0_epc,
  input  logic                 mem_busy,
  input  logic                 redirect_ready,
  output logic                 flush,
  output logic                 stall,
  output logic                 busy,
  output logic                 cp0_exc_we,
  output logic [4:0]           cp0_exc_code,
  output logic [31:0]          cp0_exc_epc,
  output logic                 cp0_exc_bd,
  output logic                 cp0_badvaddr_we,
  output logic [31:0]          cp0_badvaddr,
  output logic                 cp0_eret_we,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic [31:0]          perf_trap_cnt,
  output logic [31:0]          perf_stall_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  localparam logic [7:0] c_drain_last = 8'(DRAIN_TIMEOUT - 1);
  localparam logic [4:0] c_code_int   = 5'd0;
  localparam logic [4:0] c_code_adel  = 5'd4;
  localparam logic [4:0] c_code_ades  = 5'd5;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [4:0]  r_code;
  logic [31:0] r_pc;
  logic        r_bd;
  logic [31:0] r_badvaddr;
  logic [31:0] r_eret_tgt;
  logic        r_is_eret;
  logic        r_flush;
  logic [7:0]  r_cnt;

  logic        w_int_take;
  logic        w_accept;
  logic        w_commit_exc;

  // Interrupts are only taken when globally enabled and not already in an
  // exception/error level.
  assign w_int_take = (|int_pending) & status_ie & ~status_exl & ~status_erl;
  assign w_accept   = commit_valid & (w_int_take | exc_valid | eret_valid);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Forced exit keeps a hung bus from wedging the trap sequence.
        if (!mem_busy || (r_cnt == c_drain_last)) w_state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        w_state_nxt = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (redirect_ready) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Event capture, flush pulse and drain counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_code     <= 5'd0;
      r_pc       <= 32'd0;
      r_bd       <= 1'b0;
      r_badvaddr <= 32'd0;
      r_eret_tgt <= 32'd0;
      r_is_eret  <= 1'b0;
      r_flush    <= 1'b0;
      r_cnt      <= 8'd0;
    end else begin
      // Flush is high only for the first DRAIN cycle.
      r_flush <= (r_state == ST_IDLE) && w_accept;
      if ((r_state == ST_IDLE) && w_accept) begin
        r_code     <= w_int_take ? c_code_int : (exc_valid ? exc_code : 5'd0);
        r_is_eret  <= ~w_int_take & ~exc_valid;
        r_pc       <= commit_pc;
        r_bd       <= commit_in_delay_slot;
        r_badvaddr <= exc_badvaddr;
        r_eret_tgt <= cp0_epc;
        r_cnt      <= 8'd0;
      end else if (r_state == ST_DRAIN) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from state and captured event only
  // --------------------------------------------------------------------------
  assign w_commit_exc = (r_state == ST_COMMIT) & ~r_is_eret;

  always_comb begin
    busy            = (r_state != ST_IDLE);
    stall           = (r_state != ST_IDLE);
    flush           = r_flush;
    cp0_exc_we      = w_commit_exc;
    cp0_exc_code    = 5'd0;
    cp0_exc_epc     = 32'd0;
    cp0_exc_bd      = 1'b0;
    cp0_badvaddr_we = 1'b0;
    cp0_badvaddr    = 32'd0;
    cp0_eret_we     = (r_state == ST_COMMIT) & r_is_eret;
    redirect_valid  = (r_state == ST_REDIRECT);
    redirect_pc     = 32'd0;
    if (w_commit_exc) begin
      cp0_exc_code    = r_code;
      // A delay-slot instruction restarts at its branch.
      cp0_exc_epc     = r_bd ? (r_pc - 32'd4) : r_pc;
      cp0_exc_bd      = r_bd;
      cp0_badvaddr_we = (r_code == c_code_adel) || (r_code == c_code_ades);
      cp0_badvaddr    = r_badvaddr;
    end
    if (r_state == ST_REDIRECT) begin
      redirect_pc = r_is_eret ? r_eret_tgt : EXC_ENTRY;
    end
  end

  // --------------------------------------------------------------------------
  // Optional performance counters
  // --------------------------------------------------------------------------
`ifdef EXC_SEQ_PERF_CNT_EN
  logic [31:0] r_perf_trap;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_perf_trap  <= 32'd0;
      r_perf_stall <= 32'd0;
    end else begin
      if (r_state == ST_COMMIT) r_perf_trap <= r_perf_trap + 32'd1;
      if ((r_state == ST_DRAIN) && mem_busy) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_trap_cnt  = r_perf_trap;
  assign perf_stall_cnt = r_perf_stall;
`else
  assign perf_trap_cnt  = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_exc_commit_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_exc_commit_sequencer
// Purpose  : Self-checking bench for exc_commit_sequencer. Expected CP0
//            updates and redirect targets are queued when an event is
//            driven and compared when the DUT strobes them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exc_commit_sequencer;

  logic        clk;
  logic        resetn;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        commit_in_delay_slot;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_badvaddr;
  logic        eret_valid;
  logic [7:0]  int_pending;
  logic        status_ie;
  logic        status_exl;
  logic        status_erl;
  logic [31:0] cp0_epc;
  logic        mem_busy;
  logic        redirect_ready;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        cp0_exc_we;
  logic [4:0]  cp0_exc_code;
  logic [31:0] cp0_exc_epc;
  logic        cp0_exc_bd;
  logic        cp0_badvaddr_we;
  logic [31:0] cp0_badvaddr;
  logic        cp0_eret_we;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] perf_trap_cnt;
  logic [31:0] perf_stall_cnt;

  exc_commit_sequencer #(
    .EXC_ENTRY     (32'hBFC0_0380),
    .DRAIN_TIMEOUT (16),
    .INT_WIDTH     (8)
  ) dut (
    .clk                  (clk),
    .resetn               (resetn),
    .commit_valid         (commit_valid),
    .commit_pc            (commit_pc),
    .commit_in_delay_slot (commit_in_delay_slot),
    .exc_valid            (exc_valid),
    .exc_code             (exc_code),
    .exc_badvaddr         (exc_badvaddr),
    .eret_valid           (eret_valid),
    .int_pending          (int_pending),
    .status_ie            (status_ie),
    .status_exl           (status_exl),
    .status_erl           (status_erl),
    .cp0_epc              (cp0_epc),
    .mem_busy             (mem_busy),
    .redirect_ready       (redirect_ready),
    .flush                (flush),
    .stall                (stall),
    .busy                 (busy),
    .cp0_exc_we           (cp0_exc_we),
    .cp0_exc_code         (cp0_exc_code),
    .cp0_exc_epc          (cp0_exc_epc),
    .cp0_exc_bd           (cp0_exc_bd),
    .cp0_badvaddr_we      (cp0_badvaddr_we),
    .cp0_badvaddr         (cp0_badvaddr),
    .cp0_eret_we          (cp0_eret_we),
    .redirect_valid       (redirect_valid),
    .redirect_pc          (redirect_pc),
    .perf_trap_cnt        (perf_trap_cnt),
    .perf_stall_cnt       (perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        eret;
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bd;
    logic        bvwe;
    logic [31:0] bv;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rdr_q[$];
  exp_t        mon_e;

  int n_checks  = 0;
  int n_fail    = 0;
  int n_exc_we  = 0;
  int n_eret_we = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare CP0 strobes and redirect handshakes against queue.
  always @(negedge clk) begin
    if (resetn && (cp0_exc_we || cp0_eret_we)) begin
      if (cp0_exc_we)  n_exc_we++;
      if (cp0_eret_we) n_eret_we++;
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL strobe_without_event observed=exc%0b/eret%0b expected=none", cp0_exc_we, cp0_eret_we);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("sb_eret_we", 32'(cp0_eret_we), 32'(mon_e.eret));
        chk("sb_exc_we", 32'(cp0_exc_we), 32'(!mon_e.eret));
        if (!mon_e.eret) begin
          chk("sb_exc_code", 32'(cp0_exc_code), 32'(mon_e.code));
          chk("sb_exc_epc", cp0_exc_epc, mon_e.epc);
          chk("sb_exc_bd", 32'(cp0_exc_bd), 32'(mon_e.bd));
          chk("sb_badvaddr_we", 32'(cp0_badvaddr_we), 32'(mon_e.bvwe));
          if (mon_e.bvwe) chk("sb_badvaddr", cp0_badvaddr, mon_e.bv);
        end
      end
    end
    if (resetn && redirect_valid && redirect_ready) begin
      n_checks++;
      assert (rdr_q.size() != 0) else begin
        n_fail++;
        $error("FAIL redirect_without_event observed=0x%08h expected=none", redirect_pc);
      end
      if (rdr_q.size() != 0) chk("sb_redirect_pc", redirect_pc, rdr_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Drive one event for a single cycle and queue its expected outcome.
  task automatic launch(input logic [7:0] ip, input logic ie, input logic exl,
                        input logic exv, input logic [4:0] code, input logic erv,
                        input logic [31:0] pc, input logic bd,
                        input logic [31:0] bv, input logic [31:0] epc_in);
    exp_t e;
    logic take_int;
    commit_valid         = 1'b1;
    int_pending          = ip;
    status_ie            = ie;
    status_exl           = exl;
    status_erl           = 1'b0;
    exc_valid            = exv;
    exc_code             = code;
    eret_valid           = erv;
    commit_pc            = pc;
    commit_in_delay_slot = bd;
    exc_badvaddr         = bv;
    cp0_epc              = epc_in;
    take_int = (ip != 8'd0) && ie && !exl;
    e.eret = !take_int && !exv;
    e.code = take_int ? 5'd0 : code;
    e.epc  = bd ? (pc - 32'd4) : pc;
    e.bd   = bd;
    e.bvwe = !e.eret && ((e.code == 5'd4) || (e.code == 5'd5));
    e.bv   = bv;
    exp_q.push_back(e);
    rdr_q.push_back(e.eret ? epc_in : 32'hBFC0_0380);
    tick();
    commit_valid = 1'b0;
    exc_valid    = 1'b0;
    eret_valid   = 1'b0;
    int_pending  = 8'd0;
  endtask

  // Minimum-latency timing from T+1 through T+4 (mem_busy=0, ready=1).
  task automatic min_seq();
    smp();
    chk("t1_flush", 32'(flush), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    tick(); smp();
    chk("t2_flush_clear", 32'(flush), 32'd0);
    chk("t2_commit_strobe", 32'(cp0_exc_we | cp0_eret_we), 32'd1);
    tick(); smp();
    chk("t3_redirect_valid", 32'(redirect_valid), 32'd1);
    tick(); smp();
    chk("t4_busy_low", 32'(busy), 32'd0);
    chk("t4_stall_low", 32'(stall), 32'd0);
  endtask

  // Hold mem_busy for busy_cycles DRAIN cycles, then count DRAIN cycles.
  task automatic drain_run(input int busy_cycles, input int exp_n);
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    mem_busy = 1'b1;
    launch(8'd0, 1'b0, 1'b0, 1'b1, 5'd13, 1'b0, 32'h8000_5000, 1'b0, 32'd0, 32'd0);
    for (int k = 0; k < 64; k++) begin
      smp();
      if (cp0_exc_we) begin
        seen = 1'b1;
        break;
      end
      n++;
      tick();
      if (n == busy_cycles) mem_busy = 1'b0;
    end
    chk("drain_commit_seen", 32'(seen), 32'd1);
    chk("drain_cycles", 32'(n), 32'(exp_n));
    mem_busy = 1'b0;
    tick(); smp();
    chk("drain_redirect", 32'(redirect_valid), 32'd1);
    tick(); smp();
    chk("drain_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int exc0;
    int eret0;
    resetn               = 1'b0;
    commit_valid         = 1'b0;
    commit_pc            = 32'd0;
    commit_in_delay_slot = 1'b0;
    exc_valid            = 1'b0;
    exc_code             = 5'd0;
    exc_badvaddr         = 32'd0;
    eret_valid           = 1'b0;
    int_pending          = 8'd0;
    status_ie            = 1'b0;
    status_exl           = 1'b0;
    status_erl           = 1'b0;
    cp0_epc              = 32'd0;
    mem_busy             = 1'b0;
    redirect_ready       = 1'b1;

    // Reset state
    smp(); smp();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_exc_we", 32'(cp0_exc_we), 32'd0);
    chk("rst_eret_we", 32'(cp0_eret_we), 32'd0);
    chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_perf_trap", perf_trap_cnt, 32'd0);
    chk("rst_perf_stall", perf_stall_cnt, 32'd0);
    tick();
    resetn = 1'b1;
    tick();

    // Overflow, not in delay slot
    launch(8'd0, 1'b0, 1'b0, 1'b1, 5'd12, 1'b0, 32'h8000_1000, 1'b0, 32'h1234_5678, 32'd0);
    min_seq();

    // AdEL in a delay slot
    launch(8'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 32'h8000_2004, 1'b1, 32'h0000_0003, 32'd0);
    min_seq();

    // Interrupt + exception + ERET together; launched back-to-back at T+4
    exc0  = n_exc_we;
    eret0 = n_eret_we;
    launch(8'h04, 1'b1, 1'b0, 1'b1, 5'd10, 1'b1, 32'h8000_4000, 1'b0, 32'd0, 32'h8000_9000);
    min_seq();
    chk("prio_int_exc_pulses", 32'(n_exc_we - exc0), 32'd1);
    chk("prio_int_eret_pulses", 32'(n_eret_we - eret0), 32'd0);

    // Same with EXL set: the exception wins
    exc0  = n_exc_we;
    eret0 = n_eret_we;
    launch(8'h04, 1'b1, 1'b1, 1'b1, 5'd10, 1'b1, 32'h8000_4100, 1'b0, 32'd0, 32'h8000_9000);
    min_seq();
    chk("prio_exl_exc_pulses", 32'(n_exc_we - exc0), 32'd1);
    chk("prio_exl_eret_pulses", 32'(n_eret_we - eret0), 32'd0);
    status_exl = 1'b0;

    // ERET with a stalled redirect; events offered while busy are ignored
    eret0 = n_eret_we;
    redirect_ready = 1'b0;
    launch(8'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h8000_6000, 1'b0, 32'd0, 32'h8000_3000);
    commit_valid = 1'b1;
    exc_valid    = 1'b1;
    exc_code     = 5'd13;
    smp();
    chk("eret_t1_flush", 32'(flush), 32'd1);
    tick(); smp();
    chk("eret_t2_eret_we", 32'(cp0_eret_we), 32'd1);
    chk("eret_t2_no_exc_we", 32'(cp0_exc_we), 32'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("eret_hold_valid", 32'(redirect_valid), 32'd1);
      chk("eret_hold_pc", redirect_pc, 32'h8000_3000);
      tick();
    end
    commit_valid   = 1'b0;
    exc_valid      = 1'b0;
    redirect_ready = 1'b1;
    smp();
    chk("eret_release_valid", 32'(redirect_valid), 32'd1);
    tick(); smp();
    chk("eret_idle", 32'(busy), 32'd0);
    chk("eret_pulses", 32'(n_eret_we - eret0), 32'd1);

    // Drain: timeout with mem_busy stuck, then release after 5 cycles
    drain_run(1000, 16);
    drain_run(5, 6);

`ifdef EXC_SEQ_PERF_CNT_EN
    chk("perf_trap", perf_trap_cnt, 32'd7);
    chk("perf_stall", perf_stall_cnt, 32'd21);
`else
    chk("perf_trap_tied", perf_trap_cnt, 32'd0);
    chk("perf_stall_tied", perf_stall_cnt, 32'd0);
`endif

    // Asynchronous reset in the middle of DRAIN
    mem_busy = 1'b1;
    launch(8'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 32'h8000_7000, 1'b0, 32'd0, 32'd0);
    tick();
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_flush", 32'(flush), 32'd0);
    chk("arst_exc_we", 32'(cp0_exc_we), 32'd0);
    chk("arst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("arst_perf_trap", perf_trap_cnt, 32'd0);
    exp_q.delete();
    rdr_q.delete();
    exc0 = n_exc_we;
    tick();
    resetn   = 1'b1;
    mem_busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
    end
    smp();
    chk("post_rst_idle", 32'(busy), 32'd0);
    chk("post_rst_no_strobe", 32'(n_exc_we - exc0), 32'd0);

    // New event after reset is accepted normally
    launch(8'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 32'h8000_8008, 1'b0, 32'd0, 32'd0);
    min_seq();
    chk("sb_queue_drained", 32'(exp_q.size() + rdr_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
